// File: rtl/onn_phase_pkg.sv
// Shared definitions for the ONN phase measurement path: phase width,
// scheduler state encoding and a find-next-set-bit helper.
package onn_phase_pkg;

  localparam int PH_W   = 4;   // calculator phase port width
  localparam int MAX_N  = 32;  // widest neuron mask the helper can scan
  localparam int IDX_W  = 5;   // index width covering MAX_N
  localparam int FROM_W = 6;   // start-index width, can point one past MAX_N-1

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_NEXT    = 3'd5
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } nxt_t;

  // Lowest set bit of mask at index >= from; found=0 when there is none.
  function automatic nxt_t find_next_set(input logic [MAX_N-1:0] mask,
                                         input logic [FROM_W-1:0] from);
    nxt_t res;
    res.found = 1'b0;
    res.idx   = {IDX_W{1'b0}};
    for (int i = 0; i < MAX_N; i++) begin
      if (!res.found && mask[i] && (i >= int'(from))) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_meas_scheduler_edge.sv
// Two-flop synchronizer for the selected neuron output followed by a
// registered rising-edge detector. o_rise is a one-cycle pulse.
module phase_meas_scheduler_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_rise;

  // Synchronize the asynchronous neuron output and register its rising edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/phase_meas_scheduler.sv
// Time-shares one phase calculator across N_NEURON oscillator neurons.
// Each sweep visits the enabled neurons in index order: select and hold the
// calculator in reset, release it, wait for MIN_EDGES rising edges of the
// selected output (or a WIN_CYC timeout) and capture the phase into a
// per-neuron slot of the parallel phase snapshot.
module phase_meas_scheduler
  import onn_phase_pkg::*;
#(
  parameter int N_NEURON  = 4,
  parameter int SEL_W     = 2,
  parameter int SETTLE    = 2,
  parameter int MIN_EDGES = 2,
  parameter int WIN_CYC   = 64
) (
  input  logic                     i_sclk,
  input  logic                     i_re_n,
  input  logic                     i_start,
  input  logic                     i_cont,
  input  logic                     i_stop,
  input  logic [N_NEURON-1:0]      i_en_mask,
  input  logic                     i_sel_nout,
  input  logic [PH_W-1:0]          i_calc_phase,
  output logic                     o_calc_re,
  output logic [SEL_W-1:0]         o_calc_sel,
  output logic [N_NEURON*PH_W-1:0] o_phase_bus,
  output logic [N_NEURON-1:0]      o_phase_vld,
  output logic [N_NEURON-1:0]      o_tmo_flag,
  output logic                     o_busy,
  output logic                     o_sweep_done
);

  localparam int EC_W = $clog2(MIN_EDGES + 1);
  localparam int WC_W = $clog2(WIN_CYC);
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e                     r_state;
  logic [SEL_W-1:0]           r_idx;
  logic [N_NEURON-1:0]        r_mask;
  logic                       r_cont;
  logic [EC_W-1:0]            r_edge_cnt;
  logic [WC_W-1:0]            r_win_cnt;
  logic [SC_W-1:0]            r_set_cnt;
  logic                       r_calc_re;
  logic [N_NEURON*PH_W-1:0]   r_phase_bus;
  logic [N_NEURON-1:0]        r_phase_vld;
  logic [N_NEURON-1:0]        r_tmo_flag;
  logic                       r_busy;
  logic                       r_sweep_done;

  state_e                     w_state_nxt;
  logic [SEL_W-1:0]           w_idx_nxt;
  logic [N_NEURON-1:0]        w_mask_nxt;
  logic                       w_cont_nxt;
  logic [EC_W-1:0]            w_edge_nxt;
  logic [WC_W-1:0]            w_win_nxt;
  logic [SC_W-1:0]            w_set_nxt;
  logic [N_NEURON*PH_W-1:0]   w_bus_nxt;
  logic [N_NEURON-1:0]        w_vld_nxt;
  logic [N_NEURON-1:0]        w_tmo_nxt;
  logic                       w_done_nxt;
  logic                       w_rise;
  nxt_t                       w_first;
  nxt_t                       w_next;
  logic                       w_first_ok;
  logic                       w_next_ok;

  phase_meas_scheduler_edge u_edge (
    .i_clk   (i_sclk),
    .i_rst_n (i_re_n),
    .i_din   (i_sel_nout),
    .o_rise  (w_rise)
  );

  // Lowest enabled neuron of the live mask (sweep start) and the next
  // enabled neuron above the current one in the latched mask. The range
  // guard rejects any index that does not name a real neuron.
  assign w_first    = find_next_set(MAX_N'(i_en_mask), {FROM_W{1'b0}});
  assign w_next     = find_next_set(MAX_N'(r_mask), FROM_W'(r_idx) + FROM_W'(1));
  assign w_first_ok = w_first.found && (w_first.idx < IDX_W'(N_NEURON));
  assign w_next_ok  = w_next.found && (w_next.idx < IDX_W'(N_NEURON));

  // Next-state, counter and capture-register logic of the sweep FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mask_nxt  = r_mask;
    w_cont_nxt  = i_stop ? 1'b0 : r_cont;
    w_edge_nxt  = r_edge_cnt;
    w_win_nxt   = r_win_cnt;
    w_set_nxt   = r_set_cnt;
    w_bus_nxt   = r_phase_bus;
    w_vld_nxt   = r_phase_vld;
    w_tmo_nxt   = r_tmo_flag;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start && w_first_ok) begin
          w_mask_nxt  = i_en_mask;
          w_cont_nxt  = i_cont & ~i_stop;
          w_vld_nxt   = {N_NEURON{1'b0}};
          w_tmo_nxt   = {N_NEURON{1'b0}};
          w_idx_nxt   = SEL_W'(w_first.idx);
          w_set_nxt   = {SC_W{1'b0}};
          w_state_nxt = ST_SELECT;
        end else if (i_start) begin
          // Empty mask: report an (empty) sweep and stay idle.
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SELECT: begin
        // Counters restart here, so edges seen while settling are dropped.
        w_edge_nxt = {EC_W{1'b0}};
        w_win_nxt  = {WC_W{1'b0}};
        if (r_set_cnt == SC_W'(SETTLE - 1)) begin
          w_set_nxt   = {SC_W{1'b0}};
          w_state_nxt = ST_MEASURE;
        end else begin
          w_set_nxt   = r_set_cnt + SC_W'(1);
          w_state_nxt = ST_SELECT;
        end
      end

      ST_MEASURE: begin
        w_win_nxt = r_win_cnt + WC_W'(1);
        if (w_rise) begin
          w_edge_nxt = r_edge_cnt + EC_W'(1);
        end else begin
          w_edge_nxt = r_edge_cnt;
        end
        // The final edge wins over a timeout landing in the same cycle.
        if (w_rise && (r_edge_cnt == EC_W'(MIN_EDGES - 1))) begin
          w_state_nxt = ST_CAPTURE;
        end else if (r_win_cnt == WC_W'(WIN_CYC - 1)) begin
          w_state_nxt = ST_TIMEOUT;
        end else begin
          w_state_nxt = ST_MEASURE;
        end
      end

      ST_CAPTURE: begin
        // One cycle after the last edge the calculator phase is stable.
        w_bus_nxt[int'(r_idx)*PH_W +: PH_W] = i_calc_phase;
        w_vld_nxt[r_idx]                    = 1'b1;
        w_state_nxt                         = ST_NEXT;
      end

      ST_TIMEOUT: begin
        w_tmo_nxt[r_idx] = 1'b1;
        w_state_nxt      = ST_NEXT;
      end

      ST_NEXT: begin
        if (w_next_ok) begin
          w_idx_nxt   = SEL_W'(w_next.idx);
          w_set_nxt   = {SC_W{1'b0}};
          w_state_nxt = ST_SELECT;
        end else begin
          w_done_nxt = 1'b1;
          if (r_cont && !i_stop && w_first_ok) begin
            w_mask_nxt  = i_en_mask;
            w_vld_nxt   = {N_NEURON{1'b0}};
            w_tmo_nxt   = {N_NEURON{1'b0}};
            w_idx_nxt   = SEL_W'(w_first.idx);
            w_set_nxt   = {SC_W{1'b0}};
            w_state_nxt = ST_SELECT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any sweep at once.
  always_ff @(posedge i_sclk or negedge i_re_n) begin
    if (!i_re_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= {SEL_W{1'b0}};
      r_mask       <= {N_NEURON{1'b0}};
      r_cont       <= 1'b0;
      r_edge_cnt   <= {EC_W{1'b0}};
      r_win_cnt    <= {WC_W{1'b0}};
      r_set_cnt    <= {SC_W{1'b0}};
      r_calc_re    <= 1'b1;
      r_phase_bus  <= {(N_NEURON*PH_W){1'b0}};
      r_phase_vld  <= {N_NEURON{1'b0}};
      r_tmo_flag   <= {N_NEURON{1'b0}};
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_mask       <= w_mask_nxt;
      r_cont       <= w_cont_nxt;
      r_edge_cnt   <= w_edge_nxt;
      r_win_cnt    <= w_win_nxt;
      r_set_cnt    <= w_set_nxt;
      r_calc_re    <= !((w_state_nxt == ST_MEASURE) || (w_state_nxt == ST_CAPTURE));
      r_phase_bus  <= w_bus_nxt;
      r_phase_vld  <= w_vld_nxt;
      r_tmo_flag   <= w_tmo_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_sweep_done <= w_done_nxt;
    end
  end

  assign o_calc_re    = r_calc_re;
  assign o_calc_sel   = r_idx;
  assign o_phase_bus  = r_phase_bus;
  assign o_phase_vld  = r_phase_vld;
  assign o_tmo_flag   = r_tmo_flag;
  assign o_busy       = r_busy;
  assign o_sweep_done = r_sweep_done;

endmodule

// File: tb/tb_phase_meas_scheduler.sv
// Directed bench for phase_meas_scheduler: table of single sweeps plus
// hand-written sequences for continuous mode, reset, empty mask and the
// capture/timeout boundary.
module tb_phase_meas_scheduler;

  logic        sclk = 1'b0;
  logic        re_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  en_mask = 4'b0;
  logic        sel_nout;
  logic [3:0]  calc_phase;
  logic        calc_re;
  logic [1:0]  calc_sel;
  logic [15:0] phase_bus;
  logic [3:0]  phase_vld;
  logic [3:0]  tmo_flag;
  logic        busy;
  logic        sweep_done;

  // neuron model controls
  logic [3:0]  dead = 4'b0;
  logic        man_mode = 1'b0;
  logic        man_lvl = 1'b0;
  int          cyc = 0;
  logic        wave;

  // monitor state
  logic        mon_clr = 1'b0;
  int          done_cnt = 0;
  logic        busy_seen = 1'b0;
  logic [3:0]  vis_mask = 4'b0;
  logic        vis_any = 1'b0;
  logic        order_err = 1'b0;
  logic [1:0]  last_sel = 2'd0;
  int          re0_cnt [4] = '{0, 0, 0, 0};

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  dead;
    logic [15:0] exp_bus;
    logic [3:0]  exp_vld;
    logic [3:0]  exp_tmo;
  } vec_t;
  vec_t vecs [6];

  phase_meas_scheduler dut (
    .i_sclk       (sclk),
    .i_re_n       (re_n),
    .i_start      (start),
    .i_cont       (cont),
    .i_stop       (stop),
    .i_en_mask    (en_mask),
    .i_sel_nout   (sel_nout),
    .i_calc_phase (calc_phase),
    .o_calc_re    (calc_re),
    .o_calc_sel   (calc_sel),
    .o_phase_bus  (phase_bus),
    .o_phase_vld  (phase_vld),
    .o_tmo_flag   (tmo_flag),
    .o_busy       (busy),
    .o_sweep_done (sweep_done)
  );

  always #5 sclk = ~sclk;

  // Neurons: square wave of period 16 sclk, dead ones stuck low; phases 3,7,11,15.
  assign wave       = cyc[3];
  assign sel_nout   = man_mode ? man_lvl : (dead[calc_sel] ? 1'b0 : wave);
  assign calc_phase = {calc_sel, 2'b11};

  // Monitor: sweep_done pulses, busy, visit order and MEASURE cycles per neuron.
  always @(negedge sclk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      done_cnt  <= 0;
      busy_seen <= 1'b0;
      vis_mask  <= 4'b0;
      vis_any   <= 1'b0;
      order_err <= 1'b0;
      last_sel  <= 2'd0;
      for (int k = 0; k < 4; k++) re0_cnt[k] <= 0;
    end else begin
      if (sweep_done) done_cnt <= done_cnt + 1;
      if (busy) begin
        busy_seen <= 1'b1;
        if (!calc_re) re0_cnt[calc_sel] <= re0_cnt[calc_sel] + 1;
        if (!vis_any || calc_sel != last_sel) begin
          if (vis_any && calc_sel <= last_sel) order_err <= 1'b1;
          vis_mask[calc_sel] <= 1'b1;
          last_sel           <= calc_sel;
          vis_any            <= 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(negedge sclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    re_n = 1'b0; start = 1'b0; cont = 1'b0; stop = 1'b0; en_mask = 4'b0;
    man_mode = 1'b0; man_lvl = 1'b0; dead = 4'b0;
    tick(); tick();
    re_n = 1'b1;
    tick();
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic start_sweep(input logic [3:0] m, input logic c, input logic s);
    en_mask = m; cont = c; stop = s; start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (sweep_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_meas(input logic [1:0] sel, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (busy && !calc_re && calc_sel == sel) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{4'b1111, 4'b0000, 16'hFB73, 4'b1111, 4'b0000};
    vecs[1] = '{4'b1010, 4'b0000, 16'hF070, 4'b1010, 4'b0000};
    vecs[2] = '{4'b1111, 4'b0100, 16'hF073, 4'b1011, 4'b0100};
    vecs[3] = '{4'b0001, 4'b0000, 16'h0003, 4'b0001, 4'b0000};
    vecs[4] = '{4'b1000, 4'b0000, 16'hF000, 4'b1000, 4'b0000};
    vecs[5] = '{4'b0110, 4'b0110, 16'h0000, 4'b0000, 4'b0110};

    // reset state, sampled while reset is asserted
    tick();
    check("rst_calc_re", 32'(calc_re), 32'd1);
    check("rst_calc_sel", 32'(calc_sel), 32'd0);
    check("rst_bus", 32'(phase_bus), 32'd0);
    check("rst_vld", 32'(phase_vld), 32'd0);
    check("rst_tmo", 32'(tmo_flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);

    // table of single sweeps, each from a fresh reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      clear_mon();
      dead = vecs[v].dead;
      start_sweep(vecs[v].mask, 1'b0, 1'b0);
      wait_done(2000, ok);
      check($sformatf("v%0d_done_seen", v), 32'(ok), 32'd1);
      tick(); tick();
      check($sformatf("v%0d_bus", v), 32'(phase_bus), 32'(vecs[v].exp_bus));
      check($sformatf("v%0d_vld", v), 32'(phase_vld), 32'(vecs[v].exp_vld));
      check($sformatf("v%0d_tmo", v), 32'(tmo_flag), 32'(vecs[v].exp_tmo));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      check($sformatf("v%0d_calc_re", v), 32'(calc_re), 32'd1);
      check($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 32'd1);
      check($sformatf("v%0d_visits", v), 32'({order_err, vis_mask}), 32'({1'b0, vecs[v].mask}));
      for (int n = 0; n < 4; n++) begin
        if (vecs[v].dead[n]) check($sformatf("v%0d_win_n%0d", v, n), 32'(re0_cnt[n]), 32'd64);
      end
    end

    // continuous mode, stop during neuron 1: one sweep, then idle
    do_reset();
    clear_mon();
    start_sweep(4'b1111, 1'b1, 1'b0);
    wait_meas(2'd1, 500, ok);
    check("stop_wait_n1", 32'(ok), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_done(2000, ok);
    check("stop_done_seen", 32'(ok), 32'd1);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_vld", 32'(phase_vld), 32'hF);
    check("stop_bus", 32'(phase_bus), 32'hFB73);
    clear_mon();
    for (int k = 0; k < 100; k++) tick();
    check("stop_no_restart", 32'({busy_seen, 8'(done_cnt)}), 32'd0);

    // continuous mode wraps: restart clears flags, stop ends it after sweep 2
    do_reset();
    clear_mon();
    start_sweep(4'b0011, 1'b1, 1'b0);
    wait_done(2000, ok);
    check("cont_done1_seen", 32'(ok), 32'd1);
    check("cont_restart_busy", 32'(busy), 32'd1);
    check("cont_restart_vld", 32'(phase_vld), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_done(2000, ok);
    check("cont_done2_seen", 32'(ok), 32'd1);
    tick();
    check("cont_end_busy", 32'(busy), 32'd0);
    check("cont_end_vld", 32'(phase_vld), 32'h3);
    check("cont_done_cnt", 32'(done_cnt), 32'd2);

    // reset during MEASURE of neuron 2 clears outputs at once
    do_reset();
    start_sweep(4'b1111, 1'b0, 1'b0);
    wait_meas(2'd2, 500, ok);
    check("arst_wait_n2", 32'(ok), 32'd1);
    #2;
    re_n = 1'b0;
    #1;
    check("arst_calc_re", 32'(calc_re), 32'd1);
    check("arst_outs", 32'({calc_sel, phase_vld, tmo_flag, busy, sweep_done}), 32'd0);
    check("arst_bus", 32'(phase_bus), 32'd0);
    tick();
    re_n = 1'b1;
    tick();
    start_sweep(4'b1111, 1'b0, 1'b0);
    wait_done(2000, ok);
    check("arst_clean_done", 32'(ok), 32'd1);
    check("arst_clean_bus", 32'(phase_bus), 32'hFB73);
    check("arst_clean_vld", 32'(phase_vld), 32'hF);

    // empty mask: sweep_done one cycle later, busy never rises
    do_reset();
    clear_mon();
    start_sweep(4'b0000, 1'b0, 1'b0);
    check("empty_done", 32'(sweep_done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_calc_re", 32'(calc_re), 32'd1);
    tick();
    check("empty_done_1cyc", 32'(sweep_done), 32'd0);
    for (int k = 0; k < 10; k++) tick();
    check("empty_busy_seen", 32'({busy_seen, calc_re}), 32'h1);

    // start while busy is ignored
    do_reset();
    clear_mon();
    start_sweep(4'b0011, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    start_sweep(4'b1100, 1'b1, 1'b0);
    wait_done(2000, ok);
    check("busy_start_done", 32'(ok), 32'd1);
    check("busy_start_vld", 32'(phase_vld), 32'h3);
    check("busy_start_bus", 32'(phase_bus), 32'h0073);
    clear_mon();
    for (int k = 0; k < 80; k++) tick();
    check("busy_start_idle", 32'({busy_seen, 8'(done_cnt)}), 32'd0);

    // start and stop in the same idle cycle: single sweep
    do_reset();
    clear_mon();
    start_sweep(4'b0001, 1'b1, 1'b1);
    wait_done(2000, ok);
    check("ss_done", 32'(ok), 32'd1);
    clear_mon();
    for (int k = 0; k < 80; k++) tick();
    check("ss_idle", 32'({busy_seen, 8'(done_cnt)}), 32'd0);

    // second edge driven at MEASURE cycle 60 reaches the FSM on cycle 63
    // (three cycles of sync/edge pipeline): capture; at cycle 61: timeout
    for (int t = 0; t < 2; t++) begin
      int m_last;
      m_last = 60 + t;
      do_reset();
      man_mode = 1'b1;
      man_lvl  = 1'b0;
      start_sweep(4'b0001, 1'b0, 1'b0);
      wait_meas(2'd0, 20, ok);
      check($sformatf("edge%0d_wait", m_last), 32'(ok), 32'd1);
      for (int c = 1; c <= m_last; c++) begin
        tick();
        if (c == 5) man_lvl = 1'b1;
        if (c == 10) man_lvl = 1'b0;
        if (c == m_last) man_lvl = 1'b1;
      end
      wait_done(200, ok);
      check($sformatf("edge%0d_done", m_last), 32'(ok), 32'd1);
      check($sformatf("edge%0d_vld_tmo", m_last), 32'({phase_vld, tmo_flag}),
            (t == 0) ? 32'h10 : 32'h01);
      check($sformatf("edge%0d_bus", m_last), 32'(phase_bus), (t == 0) ? 32'h3 : 32'h0);
      man_mode = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop if the bench ever stalls.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
